// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Command controller behind a UART receiver. It parses fixed 5-byte frames
// (SOF, CMD, ADDR, DATA, CHK with CHK = CMD ^ ADDR ^ DATA), turns valid frames
// into single-cycle register write/read strobes, and returns one response byte
// through the transmitter handshake. Bad checksums and unknown commands get a
// NAK. A stall between bytes inside a frame abandons the frame without a
// response. Framing, checksum and timeout errors are counted, saturating.
//
// Ports
//   i_Clock      system clock
//   i_Reset      asynchronous reset, active-high
//   i_Rx_DV      one-cycle pulse, i_Rx_Byte is valid
//   i_Rx_Byte    received byte
//   o_Wr_En      one-cycle register write strobe
//   o_Rd_En      one-cycle register read strobe
//   o_Addr       register address, held until the next frame
//   o_Wr_Data    write data, held until the next frame
//   i_Rd_Data    read data, valid in the cycle after o_Rd_En
//   o_Tx_DV      one-cycle transmit request
//   o_Tx_Byte    response byte, stable from o_Tx_DV until i_Tx_Done
//   i_Tx_Done    one-cycle pulse, transmitter finished
//   o_Busy       high in every state except IDLE
//   o_Err_Count  saturating error count
//
// State      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for SOF; other bytes ignored
// GET_CMD    | waiting for command byte
// GET_ADDR   | waiting for address byte
// GET_DATA   | waiting for data byte
// GET_CHK    | waiting for checksum byte; decides ACK / read / NAK
// RD_WAIT    | o_Rd_En is high; read data arrives next cycle
// TX_REQ     | issue o_Tx_DV (capturing read data for reads)
// TX_WAIT    | waiting for i_Tx_Done
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CLKS = 208320,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic       o_Rd_En,
    output logic [7:0] o_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic [7:0] i_Rd_Data,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Done,
    output logic       o_Busy,
    output logic [7:0] o_Err_Count
);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    // The inter-byte timer is a down-counter. Loading TIMEOUT_CLKS-2 makes the
    // terminal count coincide with the (TIMEOUT_CLKS-1)-th idle clock after a
    // byte, which is the clock where the frame is abandoned.
    localparam logic [23:0] TMO_LOAD = 24'(TIMEOUT_CLKS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CHK,
        S_RD_WAIT,
        S_TX_REQ,
        S_TX_WAIT
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [7:0]  r_chk_acc;
    logic [23:0] r_tmo_left;
    logic        r_rd_pend;
    logic        r_wr_en;
    logic        r_rd_en;
    logic        r_tx_dv;
    logic        r_busy;
    logic [7:0]  r_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_tx_byte;
    logic [7:0]  r_err_count;

    state_t      w_state;
    logic [7:0]  w_cmd;
    logic [7:0]  w_chk_acc;
    logic [23:0] w_tmo_left;
    logic        w_rd_pend;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_tx_dv;
    logic [7:0]  w_addr;
    logic [7:0]  w_wr_data;
    logic [7:0]  w_tx_byte;
    logic        w_err_inc;
    logic [7:0]  w_err_count;
    logic        w_tmo_tc;
    logic        w_busy;

    assign w_tmo_tc = (r_tmo_left == 24'd0);

    always_comb begin
        w_state    = r_state;
        w_cmd      = r_cmd;
        w_chk_acc  = r_chk_acc;
        w_tmo_left = r_tmo_left;
        w_rd_pend  = r_rd_pend;
        w_wr_en    = 1'b0;
        w_rd_en    = 1'b0;
        w_tx_dv    = 1'b0;
        w_addr     = r_addr;
        w_wr_data  = r_wr_data;
        w_tx_byte  = r_tx_byte;
        w_err_inc  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                    w_state    = S_GET_CMD;
                    w_chk_acc  = 8'h00;
                    w_tmo_left = TMO_LOAD;
                end
            end

            S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
                // A byte landing on the terminal-count clock wins over the timeout.
                if (i_Rx_DV) begin
                    w_tmo_left = TMO_LOAD;
                    case (r_state)
                        S_GET_CMD: begin
                            w_cmd     = i_Rx_Byte;
                            w_chk_acc = r_chk_acc ^ i_Rx_Byte;
                            w_state   = S_GET_ADDR;
                        end
                        S_GET_ADDR: begin
                            w_addr    = i_Rx_Byte;
                            w_chk_acc = r_chk_acc ^ i_Rx_Byte;
                            w_state   = S_GET_DATA;
                        end
                        S_GET_DATA: begin
                            w_wr_data = i_Rx_Byte;
                            w_chk_acc = r_chk_acc ^ i_Rx_Byte;
                            w_state   = S_GET_CHK;
                        end
                        default: begin
                            if ((i_Rx_Byte == r_chk_acc) && (r_cmd == CMD_WR)) begin
                                w_wr_en   = 1'b1;
                                w_tx_byte = ACK_BYTE;
                                w_rd_pend = 1'b0;
                                w_state   = S_TX_REQ;
                            end else if ((i_Rx_Byte == r_chk_acc) && (r_cmd == CMD_RD)) begin
                                w_rd_en   = 1'b1;
                                w_rd_pend = 1'b1;
                                w_state   = S_RD_WAIT;
                            end else begin
                                w_tx_byte = NAK_BYTE;
                                w_rd_pend = 1'b0;
                                w_err_inc = 1'b1;
                                w_state   = S_TX_REQ;
                            end
                        end
                    endcase
                end else if (w_tmo_tc) begin
                    w_err_inc = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_tmo_left = r_tmo_left - 24'd1;
                end
            end

            S_RD_WAIT: begin
                w_state = S_TX_REQ;
            end

            S_TX_REQ: begin
                // Read data is valid exactly one cycle after the read strobe,
                // which is this state's cycle.
                if (r_rd_pend) begin
                    w_tx_byte = i_Rd_Data;
                end
                w_rd_pend = 1'b0;
                w_tx_dv   = 1'b1;
                w_state   = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (i_Tx_Done) begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign w_err_count = (w_err_inc && (r_err_count != 8'hFF)) ? (r_err_count + 8'd1)
                                                                : r_err_count;
    assign w_busy      = (w_state != S_IDLE);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_chk_acc   <= 8'h00;
            r_tmo_left  <= 24'd0;
            r_rd_pend   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_tx_dv     <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= 8'h00;
            r_wr_data   <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            r_state     <= w_state;
            r_cmd       <= w_cmd;
            r_chk_acc   <= w_chk_acc;
            r_tmo_left  <= w_tmo_left;
            r_rd_pend   <= w_rd_pend;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_tx_dv     <= w_tx_dv;
            r_busy      <= w_busy;
            r_addr      <= w_addr;
            r_wr_data   <= w_wr_data;
            r_tx_byte   <= w_tx_byte;
            r_err_count <= w_err_count;
        end
    end

    assign o_Wr_En     = r_wr_en;
    assign o_Rd_En     = r_rd_en;
    assign o_Addr      = r_addr;
    assign o_Wr_Data   = r_wr_data;
    assign o_Tx_DV     = r_tx_dv;
    assign o_Tx_Byte   = r_tx_byte;
    assign o_Busy      = r_busy;
    assign o_Err_Count = r_err_count;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command controller that sits behind the UART receiver. It consumes the receiver's byte stream (data-valid pulse plus byte) and parses fixed 5-byte command frames. Valid frames become single-cycle register-bus write or read strobes. One response byte is returned through a UART transmitter handshake. The block supplies the framing, integrity checking, timeout recovery and sequencing that the raw receiver lacks.

Parameters:
TIMEOUT_CLKS, 208320, idle clocks allowed between bytes inside a frame (20 bit-times at 10416 clocks per bit); must fit in 24 bits.
SOF_BYTE, 8'hA5, start-of-frame marker.
ACK_BYTE, 8'h06, response to a successful write.
NAK_BYTE, 8'h15, response to a bad checksum or unknown command.

Ports:
i_Clock  in  1  system clock; the only clock.
i_Reset  in  1  asynchronous reset, active-high.
i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte holds a received byte.
i_Rx_Byte  in  8  received byte.
o_Wr_En  out  1  one-cycle register write strobe.
o_Rd_En  out  1  one-cycle register read strobe.
o_Addr  out  8  register address; held from frame capture until the next frame.
o_Wr_Data  out  8  write data; held from frame capture until the next frame.
i_Rd_Data  in  8  read data; valid in the cycle after o_Rd_En.
o_Tx_DV  out  1  one-cycle request to transmit o_Tx_Byte.
o_Tx_Byte  out  8  response byte; stable from the o_Tx_DV cycle until i_Tx_Done.
i_Tx_Done  in  1  one-cycle pulse: transmitter finished the byte.
o_Busy  out  1  high in every state except IDLE.
o_Err_Count  out  8  saturating count of framing, checksum and timeout errors.

Behaviour:
- Frame format: SOF, CMD, ADDR, DATA, CHK.
  - CHK = CMD ^ ADDR ^ DATA.
  - CMD 8'h57 ('W') is a write; CMD 8'h52 ('R') is a read. A read frame still carries a DATA byte, which is ignored.
- Reset (async, active-high): state goes to IDLE. All outputs go to 0: o_Wr_En, o_Rd_En, o_Tx_DV, o_Busy, o_Addr, o_Wr_Data, o_Tx_Byte, o_Err_Count. The checksum accumulator and the timeout counter also clear. Reset asserted mid-frame or mid-response abandons the operation; no strobe or Tx request follows.
- All outputs are registered. States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, RD_WAIT, TX_REQ, TX_WAIT.
- IDLE:
  - i_Rx_DV with byte == SOF_BYTE -> GET_CMD; clear the checksum accumulator and the timeout counter.
  - i_Rx_DV with any other byte is ignored; no error is counted.
- GET_CMD, GET_ADDR, GET_DATA:
  - On i_Rx_DV: latch the byte (CMD, o_Addr, o_Wr_Data respectively), XOR it into the accumulator, clear the timeout counter, and advance to the next state.
- GET_CHK, on i_Rx_DV:
  - Byte == accumulator and CMD == 'W': pulse o_Wr_En in the next cycle, load o_Tx_Byte = ACK_BYTE, go to TX_REQ.
  - Byte == accumulator and CMD == 'R': pulse o_Rd_En in the next cycle, go to RD_WAIT.
  - Otherwise (checksum mismatch or unknown CMD): no strobe, o_Tx_Byte = NAK_BYTE, increment the error count, go to TX_REQ.
- Timeout: applies in GET_CMD through GET_CHK. The counter increments on each cycle with no i_Rx_DV. When it reaches TIMEOUT_CLKS-1, go to IDLE, increment the error count, and send no response. A byte arriving in that same cycle takes priority over the timeout.
- RD_WAIT: lasts one cycle (the cycle o_Rd_En is high). The next cycle is TX_REQ, in which i_Rd_Data is captured into o_Tx_Byte.
- Write latency: o_Wr_En is high exactly one cycle, starting 1 clock after the cycle in which the CHK i_Rx_DV is sampled. o_Tx_DV follows 1 clock later.
- Read latency: o_Rd_En is high 1 clock after the CHK i_Rx_DV; i_Rd_Data is captured 1 clock after that.
- TX_REQ: assert o_Tx_DV for exactly one cycle, then go to TX_WAIT.
- TX_WAIT: hold until i_Tx_Done, then go to IDLE.
- Bytes received in RD_WAIT, TX_REQ or TX_WAIT are dropped silently and never start a frame.
- o_Err_Count saturates at 8'hFF; it does not wrap.

Test Plan:
- Write frame A5 57 10 3C 7B -> o_Wr_En high for 1 cycle with o_Addr=8'h10, o_Wr_Data=8'h3C; o_Tx_DV then sends 8'h06; after i_Tx_Done, o_Busy drops; o_Err_Count stays 0.
- Read frame A5 52 22 00 70, with i_Rd_Data=8'h9E in the cycle after o_Rd_En -> o_Rd_En pulses once with o_Addr=8'h22; o_Tx_Byte=8'h9E; o_Wr_En is never asserted.
- Bad checksum A5 57 10 3C 00 -> no o_Wr_En; o_Tx_Byte=8'h15; o_Err_Count=1. Separately, unknown CMD A5 41 00 00 41 -> NAK and o_Err_Count increments.
- Noise bytes 00 FF 5A before a valid write frame -> ignored, the write executes normally, o_Err_Count=0. Bytes injected during TX_WAIT -> dropped, no new frame starts.
- Timeout: A5 57 then silence -> exactly TIMEOUT_CLKS-1 idle clocks later the state is IDLE, o_Err_Count=1, no o_Tx_DV. A following valid frame completes normally. Also cover a byte arriving exactly at the terminal count -> it is accepted.
- Reset: assert i_Reset after A5 57 10 -> all outputs are 0 immediately (asynchronous). After release, a full valid frame executes. Also cover 256 bad frames -> o_Err_Count=8'hFF.
